proc_ctrl_fsm: RTL and testbench

// Multi-cycle control unit for the distributed processor core, successor to the single-cycle opcode decoder.

---
 rtl/proc_ctrl_pkg.sv | 44 ++++
 rtl/ctrl_wait_cnt.sv | 31 +++
 rtl/proc_ctrl_fsm.sv | 235 +++++++++++++++++++++++
 tb/tb_proc_ctrl_fsm.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the multi-cycle processor control unit:
// opcode class codes, controller states and datapath select encodings.
`default_nettype none

package proc_ctrl_pkg;

   localparam int unsigned CLS_REG_ALU     = 1;
   localparam int unsigned CLS_REG_I_ALU   = 2;
   localparam int unsigned CLS_REG_WRITE   = 3;
   localparam int unsigned CLS_JUMP_I      = 4;
   localparam int unsigned CLS_JUMP_COND   = 5;
   localparam int unsigned CLS_INC_QCLK    = 6;
   localparam int unsigned CLS_PULSE       = 8;
   localparam int unsigned CLS_PULSE_TIMED = 9;
   localparam int unsigned CLS_SYNC        = 10;
   localparam int unsigned CLS_FPROC       = 11;
   localparam int unsigned CLS_DONE        = 15;

   typedef enum logic [2:0] {
      S_FETCH      = 3'd0,
      S_DECODE     = 3'd1,
      S_ALU_WAIT   = 3'd2,
      S_PULSE_WAIT = 3'd3,
      S_SYNC_WAIT  = 3'd4,
      S_FPROC_WAIT = 3'd5,
      S_DONE       = 3'd6,
      S_ERR        = 3'd7
   } ctrl_state_e;

   localparam logic [1:0] WSEL_CMD   = 2'd0;
   localparam logic [1:0] WSEL_ALU   = 2'd1;
   localparam logic [1:0] WSEL_FPROC = 2'd2;

   localparam logic ASEL_CMD = 1'b0;
   localparam logic ASEL_REG = 1'b1;

   function automatic logic is_alu_class(input int unsigned cls);
      return (cls == CLS_REG_ALU) || (cls == CLS_REG_I_ALU) ||
             (cls == CLS_JUMP_COND) || (cls == CLS_INC_QCLK);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_wait_cnt.sv
// Loadable down-counter shared by the fetch and ALU latency waits.
`default_nettype none

module ctrl_wait_cnt #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute controller; every control output is registered
// and reflects the action of the cycle the controller is currently in.
`default_nettype none

module proc_ctrl_fsm
   import proc_ctrl_pkg::*;
#(
   parameter int OPCODE_WIDTH    = 8,
   parameter int MEM_READ_CYCLES = 2,
   parameter int ALU_LATENCY     = 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    alu_cond,
   input  logic                    qclk_trig,
   input  logic                    sync_ready,
   input  logic                    fproc_ready,
   output logic [2:0]              alu_opcode,
   output logic                    alu_in0_sel,
   output logic                    alu_in1_sel,
   output logic                    reg_write_en,
   output logic [1:0]              reg_write_sel,
   output logic                    c_strobe_enable,
   output logic                    instr_ptr_en,
   output logic                    instr_ptr_load_en,
   output logic                    qclk_load_en,
   output logic                    mem_read_en,
   output logic                    sync_out_valid,
   output logic                    fproc_out_valid,
   output logic                    done_gate,
   output logic                    err_illegal
);

   localparam int CLS_W    = OPCODE_WIDTH - 3;
   localparam int MAX_WAIT = (MEM_READ_CYCLES > ALU_LATENCY) ? MEM_READ_CYCLES : ALU_LATENCY;
   localparam int CNT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] FETCH_PRELOAD = CNT_W'(MEM_READ_CYCLES - 1);
   localparam logic [CNT_W-1:0] ALU_PRELOAD   = CNT_W'((ALU_LATENCY > 1) ? ALU_LATENCY - 2 : 0);

   ctrl_state_e       state;
   logic [CLS_W-1:0]  cls_reg;
   logic              retire;
   int unsigned       cls_in;
   int unsigned       cls_q;
   logic              cnt_load;
   logic              cnt_dec;
   logic              cnt_zero;
   logic [CNT_W-1:0]  cnt_load_val;
   logic              alu_fin;
   logic              pulse_fire;

   assign cls_in = 32'(opcode[OPCODE_WIDTH-1:3]);
   assign cls_q  = 32'(cls_reg);

   // retire marks the last cycle of an instruction; the next edge always restarts FETCH
   always_comb begin
      alu_fin = 1'b0;
      if (!retire) begin
         if ((state == S_DECODE) && is_alu_class(cls_q) && (ALU_LATENCY == 1)) begin
            alu_fin = 1'b1;
         end
         if ((state == S_ALU_WAIT) && cnt_zero) begin
            alu_fin = 1'b1;
         end
      end
   end

   assign pulse_fire = !retire && qclk_trig &&
                       ((state == S_PULSE_WAIT) ||
                        ((state == S_DECODE) && (cls_q == CLS_PULSE_TIMED)));

   assign cnt_load     = retire || ((state == S_FETCH) && !mem_read_en) ||
                         ((state == S_DECODE) && is_alu_class(cls_q));
   assign cnt_load_val = ((state == S_DECODE) && !retire) ? ALU_PRELOAD : FETCH_PRELOAD;
   assign cnt_dec      = ((state == S_FETCH) && mem_read_en) ||
                         ((state == S_ALU_WAIT) && !retire);

   ctrl_wait_cnt #(
      .WIDTH (CNT_W)
   ) u_wait_cnt (
      .clk      (clk),
      .rstn     (rstn),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state             <= S_FETCH;
         cls_reg           <= '0;
         retire            <= 1'b0;
         alu_opcode        <= '0;
         alu_in0_sel       <= ASEL_CMD;
         alu_in1_sel       <= ASEL_CMD;
         reg_write_en      <= 1'b0;
         reg_write_sel     <= WSEL_CMD;
         c_strobe_enable   <= 1'b0;
         instr_ptr_en      <= 1'b0;
         instr_ptr_load_en <= 1'b0;
         qclk_load_en      <= 1'b0;
         mem_read_en       <= 1'b0;
         sync_out_valid    <= 1'b0;
         fproc_out_valid   <= 1'b0;
         done_gate         <= 1'b0;
         err_illegal       <= 1'b0;
      end else begin
         reg_write_en      <= 1'b0;
         reg_write_sel     <= WSEL_CMD;
         c_strobe_enable   <= 1'b0;
         instr_ptr_en      <= 1'b0;
         instr_ptr_load_en <= 1'b0;
         qclk_load_en      <= 1'b0;
         retire            <= 1'b0;

         if (retire) begin
            state       <= S_FETCH;
            mem_read_en <= 1'b1;
            alu_in0_sel <= ASEL_CMD;
            alu_in1_sel <= ASEL_CMD;
         end else begin
            case (state)
               S_FETCH: begin
                  if (!mem_read_en) begin
                     mem_read_en <= 1'b1;
                  end else if (cnt_zero) begin
                     mem_read_en <= 1'b0;
                     cls_reg     <= opcode[OPCODE_WIDTH-1:3];
                     alu_opcode  <= opcode[2:0];
                     state       <= S_DECODE;
                     // Single-cycle classes act in the decode cycle itself
                     case (cls_in)
                        CLS_PULSE: begin
                           c_strobe_enable <= 1'b1;
                           instr_ptr_en    <= 1'b1;
                           retire          <= 1'b1;
                        end
                        CLS_REG_WRITE: begin
                           reg_write_en  <= 1'b1;
                           reg_write_sel <= WSEL_CMD;
                           instr_ptr_en  <= 1'b1;
                           retire        <= 1'b1;
                        end
                        CLS_JUMP_I: begin
                           instr_ptr_load_en <= 1'b1;
                           retire            <= 1'b1;
                        end
                        CLS_REG_ALU: begin
                           alu_in0_sel <= ASEL_REG;
                           alu_in1_sel <= ASEL_REG;
                        end
                        CLS_REG_I_ALU, CLS_JUMP_COND, CLS_INC_QCLK: begin
                           alu_in1_sel <= ASEL_REG;
                        end
                        default: ;
                     endcase
                  end
               end
               S_DECODE: begin
                  if (is_alu_class(cls_q)) begin
                     state <= S_ALU_WAIT;
                  end else begin
                     case (cls_q)
                        CLS_PULSE_TIMED: state <= S_PULSE_WAIT;
                        CLS_SYNC: begin
                           state          <= S_SYNC_WAIT;
                           sync_out_valid <= 1'b1;
                        end
                        CLS_FPROC: begin
                           state           <= S_FPROC_WAIT;
                           fproc_out_valid <= 1'b1;
                        end
                        CLS_DONE: begin
                           state     <= S_DONE;
                           done_gate <= 1'b1;
                        end
                        default: begin
                           state       <= S_ERR;
                           err_illegal <= 1'b1;
                        end
                     endcase
                  end
               end
               S_SYNC_WAIT: begin
                  if (sync_ready) begin
                     sync_out_valid <= 1'b0;
                     instr_ptr_en   <= 1'b1;
                     retire         <= 1'b1;
                  end
               end
               S_FPROC_WAIT: begin
                  if (fproc_ready) begin
                     fproc_out_valid <= 1'b0;
                     reg_write_en    <= 1'b1;
                     reg_write_sel   <= WSEL_FPROC;
                     instr_ptr_en    <= 1'b1;
                     retire          <= 1'b1;
                  end
               end
               default: ;
            endcase

            if (alu_fin) begin
               retire <= 1'b1;
               case (cls_q)
                  CLS_JUMP_COND: begin
                     instr_ptr_load_en <= alu_cond;
                     instr_ptr_en      <= !alu_cond;
                  end
                  CLS_INC_QCLK: begin
                     qclk_load_en <= 1'b1;
                     instr_ptr_en <= 1'b1;
                  end
                  default: begin
                     reg_write_en  <= 1'b1;
                     reg_write_sel <= WSEL_ALU;
                     instr_ptr_en  <= 1'b1;
                  end
               endcase
            end

            if (pulse_fire) begin
               c_strobe_enable <= 1'b1;
               instr_ptr_en    <= 1'b1;
               retire          <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_proc_ctrl_fsm.sv
// Directed scoreboard bench: each instruction pushes its expected per-cycle output
// trace (plus the handshake inputs to drive) and the trace is replayed against the DUT.
`default_nettype none

module tb_proc_ctrl_fsm;
   import proc_ctrl_pkg::*;

   localparam int OW  = 8;
   localparam int MRC = 3;
   localparam int AL  = 2;

   typedef struct packed {
      logic       mem;
      logic       rw;
      logic [1:0] sel;
      logic       stb;
      logic       ip;
      logic       ipl;
      logic       qld;
      logic       sv;
      logic       fv;
      logic       dn;
      logic       er;
      logic       in0;
      logic       in1;
      logic [2:0] aop;
   } out_t;

   typedef struct packed {
      out_t o;
      logic trig;
      logic srdy;
      logic frdy;
   } step_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [OW-1:0] opcode = '0;
   logic          alu_cond = 1'b0;
   logic          qclk_trig = 1'b0;
   logic          sync_ready = 1'b0;
   logic          fproc_ready = 1'b0;
   logic [2:0]    alu_opcode;
   logic          alu_in0_sel, alu_in1_sel, reg_write_en;
   logic [1:0]    reg_write_sel;
   logic          c_strobe_enable, instr_ptr_en, instr_ptr_load_en, qclk_load_en;
   logic          mem_read_en, sync_out_valid, fproc_out_valid, done_gate, err_illegal;

   int         checks = 0;
   int         errors = 0;
   logic [2:0] cur_aop = 3'd0;
   step_t      sb[$];

   always #5 clk = ~clk;

   proc_ctrl_fsm #(
      .OPCODE_WIDTH    (OW),
      .MEM_READ_CYCLES (MRC),
      .ALU_LATENCY     (AL)
   ) dut (
      .clk               (clk),
      .rstn              (rstn),
      .opcode            (opcode),
      .alu_cond          (alu_cond),
      .qclk_trig         (qclk_trig),
      .sync_ready        (sync_ready),
      .fproc_ready       (fproc_ready),
      .alu_opcode        (alu_opcode),
      .alu_in0_sel       (alu_in0_sel),
      .alu_in1_sel       (alu_in1_sel),
      .reg_write_en      (reg_write_en),
      .reg_write_sel     (reg_write_sel),
      .c_strobe_enable   (c_strobe_enable),
      .instr_ptr_en      (instr_ptr_en),
      .instr_ptr_load_en (instr_ptr_load_en),
      .qclk_load_en      (qclk_load_en),
      .mem_read_en       (mem_read_en),
      .sync_out_valid    (sync_out_valid),
      .fproc_out_valid   (fproc_out_valid),
      .done_gate         (done_gate),
      .err_illegal       (err_illegal)
   );

   function automatic out_t observe();
      out_t o;
      o.mem = mem_read_en;       o.rw  = reg_write_en;     o.sel = reg_write_sel;
      o.stb = c_strobe_enable;   o.ip  = instr_ptr_en;     o.ipl = instr_ptr_load_en;
      o.qld = qclk_load_en;      o.sv  = sync_out_valid;   o.fv  = fproc_out_valid;
      o.dn  = done_gate;         o.er  = err_illegal;      o.in0 = alu_in0_sel;
      o.in1 = alu_in1_sel;       o.aop = alu_opcode;
      return o;
   endfunction

   function automatic step_t blank();
      step_t s;
      s = '0;
      s.o.aop = cur_aop;
      return s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drain(input string name);
      step_t e;
      int    n;
      n = 0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(posedge clk);
         #1;
         chk($sformatf("%s cyc%0d", name, n), 32'(observe()), 32'(e.o));
         qclk_trig   = e.trig;
         sync_ready  = e.srdy;
         fproc_ready = e.frdy;
         n++;
      end
   endtask

   task automatic do_reset(input string name);
      rstn = 1'b0;
      #1;
      chk({name, " outputs"}, 32'(observe()), 32'd0);
      chk({name, " state"}, 32'(dut.state), 32'(S_FETCH));
      cur_aop = 3'd0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic push_fetch(input logic [OW-1:0] op);
      step_t s;
      opcode = op;
      repeat (MRC) begin
         s = blank();
         s.o.mem = 1'b1;
         sb.push_back(s);
      end
      cur_aop = op[2:0];
   endtask

   // wait_n: cycles before the awaited handshake, or terminal cycles to observe
   task automatic instr(input string name, input logic [OW-1:0] op, input int wait_n, input logic cond);
      step_t       s;
      int unsigned cls;
      cls      = 32'(op[OW-1:3]);
      alu_cond = cond;
      push_fetch(op);
      s = blank();
      case (cls)
         CLS_PULSE:     begin s.o.stb = 1'b1; s.o.ip = 1'b1; sb.push_back(s); end
         CLS_REG_WRITE: begin s.o.rw = 1'b1; s.o.sel = WSEL_CMD; s.o.ip = 1'b1; sb.push_back(s); end
         CLS_JUMP_I:    begin s.o.ipl = 1'b1; sb.push_back(s); end
         CLS_REG_ALU, CLS_REG_I_ALU, CLS_JUMP_COND, CLS_INC_QCLK: begin
            s.o.in0 = (cls == CLS_REG_ALU);
            s.o.in1 = 1'b1;
            repeat (AL) sb.push_back(s);
            if (cls == CLS_JUMP_COND) begin
               s.o.ipl = cond;
               s.o.ip  = !cond;
            end else if (cls == CLS_INC_QCLK) begin
               s.o.qld = 1'b1;
               s.o.ip  = 1'b1;
            end else begin
               s.o.rw  = 1'b1;
               s.o.sel = WSEL_ALU;
               s.o.ip  = 1'b1;
            end
            sb.push_back(s);
         end
         CLS_PULSE_TIMED: begin
            s.trig = (wait_n == 0);
            sb.push_back(s);
            for (int i = 1; i <= wait_n; i++) begin
               s = blank();
               s.trig = (i == wait_n);
               sb.push_back(s);
            end
            s = blank();
            s.o.stb = 1'b1;
            s.o.ip  = 1'b1;
            sb.push_back(s);
         end
         CLS_SYNC, CLS_FPROC: begin
            sb.push_back(s);
            for (int i = 1; i <= wait_n; i++) begin
               s = blank();
               if (cls == CLS_SYNC) begin
                  s.o.sv = 1'b1;
                  s.srdy = (i == wait_n);
               end else begin
                  s.o.fv = 1'b1;
                  s.frdy = (i == wait_n);
               end
               sb.push_back(s);
            end
            s = blank();
            s.o.ip = 1'b1;
            if (cls == CLS_FPROC) begin
               s.o.rw  = 1'b1;
               s.o.sel = WSEL_FPROC;
            end
            sb.push_back(s);
         end
         default: begin
            sb.push_back(s);
            repeat (wait_n) begin
               s = blank();
               if (cls == CLS_DONE) s.o.dn = 1'b1;
               else                 s.o.er = 1'b1;
               sb.push_back(s);
            end
         end
      endcase
      drain(name);
   endtask

   initial begin
      step_t s;
      repeat (2) @(posedge clk);
      do_reset("reset");

      instr("reg_write",     8'h1A, 0, 1'b0);
      instr("pulse",         8'h45, 0, 1'b0);
      instr("jump_i",        8'h23, 0, 1'b0);
      instr("reg_alu",       8'h0D, 0, 1'b0);
      instr("reg_i_alu",     8'h16, 0, 1'b0);
      instr("jump_cond_t",   8'h29, 0, 1'b1);
      instr("jump_cond_f",   8'h2E, 0, 1'b0);
      instr("inc_qclk",      8'h37, 0, 1'b0);
      instr("pulse_timed5",  8'h49, 5, 1'b0);
      instr("pulse_timed0",  8'h4B, 0, 1'b0);
      instr("sync",          8'h52, 3, 1'b0);
      instr("fproc",         8'h5C, 4, 1'b0);

      // abort a REG_ALU in its first ALU_WAIT cycle
      push_fetch(8'h0D);
      s = blank();
      s.o.in0 = 1'b1;
      s.o.in1 = 1'b1;
      sb.push_back(s);
      sb.push_back(s);
      drain("alu_abort");
      do_reset("abort_reset");
      instr("after_abort",   8'h19, 0, 1'b0);

      instr("done",          8'h7B, 4, 1'b0);
      do_reset("done_reset");
      instr("illegal_31",    8'hF8, 4, 1'b0);
      do_reset("err_reset");
      instr("illegal_7",     8'h3C, 3, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
